// File: rtl/fwd_sel_hazard_unit.sv
// Forwarding-select and load-use hazard unit: registers the EX-stage operand mux
// selects alongside ID/EX and inserts a one-cycle bubble on load-use dependencies.
module fwd_sel_hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  Hold,
    input  logic                  Flush,
    input  logic [REG_ADDR_W-1:0] ID_Rs,
    input  logic [REG_ADDR_W-1:0] ID_Rt,
    input  logic                  ID_UseRs,
    input  logic                  ID_UseRt,
    input  logic [REG_ADDR_W-1:0] EX_Dst,
    input  logic                  EX_RegWrite,
    input  logic                  EX_MemRead,
    input  logic [REG_ADDR_W-1:0] MEM_Dst,
    input  logic                  MEM_RegWrite,
    input  logic [REG_ADDR_W-1:0] WB_Dst,
    input  logic                  WB_RegWrite,
    output logic [1:0]            FwdA_Sel,
    output logic [1:0]            FwdB_Sel,
    output logic                  Stall,
    output logic                  EX_Bubble,
    output logic [CNT_W-1:0]      StallCount
);

    typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_e;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b11;

    state_e           state_q, state_d;
    logic [1:0]       fwd_a_q, fwd_a_d;
    logic [1:0]       fwd_b_q, fwd_b_d;
    logic             bubble_q, bubble_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use;
    logic             stall_c;

    // Youngest producer wins; register 0 is never forwarded.
    function automatic logic [1:0] fwd_code(input logic [REG_ADDR_W-1:0] src,
                                            input logic                  use_src);
        logic [1:0] code;
        code = SEL_RF;
        if (use_src && (src != '0)) begin
            if (EX_RegWrite && (EX_Dst == src))        code = SEL_EX;
            else if (MEM_RegWrite && (MEM_Dst == src)) code = SEL_MEM;
            else if (WB_RegWrite && (WB_Dst == src))   code = SEL_WB;
        end
        return code;
    endfunction

    assign load_use = EX_MemRead && EX_RegWrite && (EX_Dst != '0) &&
                      ((ID_UseRs && (EX_Dst == ID_Rs)) ||
                       (ID_UseRt && (EX_Dst == ID_Rt)));

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d  = state_q;
        fwd_a_d  = fwd_a_q;
        fwd_b_d  = fwd_b_q;
        bubble_d = bubble_q;
        cnt_d    = cnt_q;
        stall_c  = 1'b0;

        // In STALL the bubble occupies EX, so a second stall cannot be raised.
        if (state_q == RUN) begin
            stall_c = load_use && !Flush && !Hold && Rst_n;
        end

        if (!Hold) begin
            if (Flush) begin
                fwd_a_d  = SEL_RF;
                fwd_b_d  = SEL_RF;
                bubble_d = 1'b1;
                state_d  = RUN;
            end else if (stall_c) begin
                fwd_a_d  = SEL_RF;
                fwd_b_d  = SEL_RF;
                bubble_d = 1'b1;
                state_d  = STALL;
                if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            end else begin
                fwd_a_d  = fwd_code(ID_Rs, ID_UseRs);
                fwd_b_d  = fwd_code(ID_Rt, ID_UseRt);
                bubble_d = 1'b0;
                state_d  = RUN;
            end
        end
    end

    // NOTE: only control/status flops here, so all of them take the async reset.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= RUN;
            fwd_a_q  <= SEL_RF;
            fwd_b_q  <= SEL_RF;
            bubble_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            fwd_a_q  <= fwd_a_d;
            fwd_b_q  <= fwd_b_d;
            bubble_q <= bubble_d;
            cnt_q    <= cnt_d;
        end
    end

    assign FwdA_Sel   = fwd_a_q;
    assign FwdB_Sel   = fwd_b_q;
    assign Stall      = stall_c;
    assign EX_Bubble  = bubble_q;
    assign StallCount = cnt_q;

endmodule
